// File: rtl/mul_pkg.sv
// Shared widths and dispatcher FSM encoding for users of the iterative multiplier.
package mul_pkg;
   localparam int DATA_W = 32;
   localparam int RES_W  = 64;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_HOLD  = 2'd3
   } state_t;
endpackage

// File: rtl/mul_dispatch_fifo.sv
// Operand/tag queue in front of the multiplier; DEPTH must be a power of two so
// the read and write pointers wrap naturally.
module mul_dispatch_fifo
   import mul_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 2 * DATA_W + 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (i_push && !i_pop)      r_count <= r_count + (PTR_W+1)'(1);
         else if (i_pop && !i_push) r_count <= r_count - (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
   assign o_empty = (r_count == '0);
endmodule

// File: rtl/mul_dispatch.sv
// Queues operand pairs and feeds them one at a time to an iterative multiplier,
// returning each product (or a timeout marker) with its caller tag, in order.
//
// state | meaning
// IDLE  | nothing in flight, waiting for a queued pair
// ISSUE | one-cycle start pulse, head popped, tag captured
// WAIT  | waiting for multiplier done or timeout
// HOLD  | response presented until downstream accepts it
module mul_dispatch
   import mul_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 2,
   parameter int TIMEOUT = 63
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DATA_W-1:0] req_a,
   input  logic [DATA_W-1:0] req_b,
   input  logic [TAG_W-1:0]  req_tag,
   output logic              mul_valid_in,
   output logic [DATA_W-1:0] mul_a,
   output logic [DATA_W-1:0] mul_b,
   input  logic              mul_valid_out,
   input  logic [RES_W-1:0]  mul_r,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [RES_W-1:0]  rsp_r,
   output logic [TAG_W-1:0]  rsp_tag,
   output logic              rsp_err,
   output logic              busy
);
   localparam int         FW       = 2 * DATA_W + TAG_W;
   localparam logic [5:0] CNT_LAST = 6'(TIMEOUT - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [DATA_W-1:0]   r_mul_a;
   logic [DATA_W-1:0]   r_mul_b;
   logic [TAG_W-1:0]    r_tag;
   logic [RES_W-1:0]    r_rsp_r;
   logic                r_rsp_err;
   logic [5:0]          r_cnt;

   logic                w_push;
   logic                w_pop;
   logic                w_full;
   logic                w_empty;
   logic                w_timeout;
   logic [FW-1:0]       w_head;
   logic [DATA_W-1:0]   w_head_a;
   logic [DATA_W-1:0]   w_head_b;
   logic [TAG_W-1:0]    w_head_tag;

   assign w_push     = req_valid && !w_full;
   assign w_pop      = (r_state == S_ISSUE);
   assign w_head_tag = w_head[FW-1 -: TAG_W];
   assign w_head_a   = w_head[2*DATA_W-1 -: DATA_W];
   assign w_head_b   = w_head[DATA_W-1:0];
   assign w_timeout  = (r_cnt == CNT_LAST);

   mul_dispatch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FW)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  ({req_tag, req_a, req_b}),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (!w_empty) w_state_nxt = S_ISSUE;
         S_ISSUE: w_state_nxt = S_WAIT;
         S_WAIT:  if (mul_valid_out || w_timeout) w_state_nxt = S_HOLD;
         S_HOLD:  if (rsp_ready) w_state_nxt = w_empty ? S_IDLE : S_ISSUE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mul_a   <= '0;
         r_mul_b   <= '0;
         r_tag     <= '0;
         r_rsp_r   <= '0;
         r_rsp_err <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_cnt <= (r_state == S_WAIT) ? r_cnt + 6'd1 : 6'd0;
         if (r_state == S_ISSUE) begin
            r_mul_a <= w_head_a;
            r_mul_b <= w_head_b;
            r_tag   <= w_head_tag;
         end
         // A real done wins over a timeout landing on the same cycle.
         if (r_state == S_WAIT) begin
            if (mul_valid_out) begin
               r_rsp_r   <= mul_r;
               r_rsp_err <= 1'b0;
            end else if (w_timeout) begin
               r_rsp_r   <= '0;
               r_rsp_err <= 1'b1;
            end
         end
      end
   end

   assign req_ready    = !w_full;
   assign mul_valid_in = (r_state == S_ISSUE);
   assign mul_a        = (r_state == S_ISSUE) ? w_head_a : r_mul_a;
   assign mul_b        = (r_state == S_ISSUE) ? w_head_b : r_mul_b;
   assign rsp_valid    = (r_state == S_HOLD);
   assign rsp_r        = r_rsp_r;
   assign rsp_tag      = r_tag;
   assign rsp_err      = r_rsp_err;
   assign busy         = !w_empty || (r_state != S_IDLE);
endmodule

// File: tb/tb_mul_dispatch.sv
// Directed bench for mul_dispatch with a behavioural iterative-multiplier stub.
module tb_mul_dispatch;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic [1:0]  req_tag = '0;
   logic        mul_valid_in;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic        mul_valid_out = 1'b0;
   logic [63:0] mul_r = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [63:0] rsp_r;
   logic [1:0]  rsp_tag;
   logic        rsp_err;
   logic        busy;

   int n_chk = 0;
   int n_err = 0;
   int pulses = 0;

   mul_dispatch #(.DEPTH(4), .TAG_W(2), .TIMEOUT(63)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
      .mul_valid_in(mul_valid_in), .mul_a(mul_a), .mul_b(mul_b),
      .mul_valid_out(mul_valid_out), .mul_r(mul_r),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_r(rsp_r), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Multiplier stub: done rises 32 edges after the start pulse is sampled.
   logic        stub_never = 1'b0;
   logic        stub_hold  = 1'b0;
   logic        stub_busy  = 1'b0;
   int          stub_cnt   = 0;
   logic [31:0] stub_a     = '0;
   logic [31:0] stub_b     = '0;

   always @(posedge clk) begin
      if (mul_valid_in) begin
         stub_busy     <= 1'b1;
         stub_cnt      <= 32;
         stub_a        <= mul_a;
         stub_b        <= mul_b;
         mul_valid_out <= 1'b0;
      end else if (stub_busy) begin
         if (stub_cnt == 1) begin
            stub_busy <= 1'b0;
            if (!stub_never) begin
               mul_valid_out <= 1'b1;
               mul_r         <= {32'd0, stub_a} * {32'd0, stub_b};
            end
         end else begin
            stub_cnt <= stub_cnt - 1;
         end
      end else if (!stub_hold) begin
         mul_valid_out <= 1'b0;
      end
   end

   always @(negedge clk) if (mul_valid_in) pulses++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  tag;
      logic [63:0] r;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_req_ready"},    64'(req_ready),    64'd1);
      chk({pfx, "_mul_valid_in"}, 64'(mul_valid_in), 64'd0);
      chk({pfx, "_mul_a"},        64'(mul_a),        64'd0);
      chk({pfx, "_mul_b"},        64'(mul_b),        64'd0);
      chk({pfx, "_rsp_valid"},    64'(rsp_valid),    64'd0);
      chk({pfx, "_rsp_r"},        rsp_r,             64'd0);
      chk({pfx, "_rsp_tag"},      64'(rsp_tag),      64'd0);
      chk({pfx, "_rsp_err"},      64'(rsp_err),      64'd0);
      chk({pfx, "_busy"},         64'(busy),         64'd0);
   endtask

   // Called #1 after an edge; returns #1 after the accepting edge.
   task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [1:0] tag);
      int   n = 0;
      logic acc = 1'b0;
      req_valid = 1'b1;
      req_a     = a;
      req_b     = b;
      req_tag   = tag;
      while (!acc && n < 300) begin
         acc = req_ready;
         @(posedge clk); #1;
         n++;
      end
      req_valid = 1'b0;
      if (!acc) chk("push_accept_timeout", 64'(acc), 64'd1);
   endtask

   // Waits for rsp_valid, samples it, then completes the handshake.
   task automatic get_rsp(output logic [63:0] r, output logic [1:0] tag,
                          output logic err, output int n);
      n = 0;
      rsp_ready = 1'b1;
      while (!rsp_valid && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      if (!rsp_valid) chk("rsp_wait_timeout", 64'(rsp_valid), 64'd1);
      r   = rsp_r;
      tag = rsp_tag;
      err = rsp_err;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [63:0] r;
      logic [1:0]  tag;
      logic        err;
      int          n;
      int          p0;
      int          seen;

      vecs[0] = '{32'd10,         32'd20,         2'd1, 64'd200};
      vecs[1] = '{32'h0000_FFFF,  32'h0000_FFFF,  2'd2, 64'h0000_0000_FFFE_0001};
      vecs[2] = '{32'd0,          32'h0000_1234,  2'd3, 64'd0};
      vecs[3] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  2'd0, 64'hFFFF_FFFE_0000_0001};
      vecs[4] = '{32'h8000_0000,  32'd2,          2'd1, 64'h0000_0001_0000_0000};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("rst");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single op with latency measurement
      p0 = pulses;
      push(32'd3, 32'd5, 2'd1);
      get_rsp(r, tag, err, n);
      chk("single_latency", 64'(n), 64'd35);
      chk("single_r",       r,      64'd15);
      chk("single_tag",     64'(tag), 64'd1);
      chk("single_err",     64'(err), 64'd0);
      chk("single_pulses",  64'(pulses - p0), 64'd1);

      // Backpressure on a blocker response, filling the queue behind it
      rsp_ready = 1'b0;
      push(32'd7, 32'd9, 2'd0);
      n = 0;
      while (!rsp_valid && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp_blocker_valid", 64'(rsp_valid), 64'd1);
      chk("bp_blocker_r",     rsp_r,          64'd63);
      for (int i = 0; i < 4; i++) push(vecs[i].a, vecs[i].b, vecs[i].tag);
      chk("fill_ready_low", 64'(req_ready), 64'd0);
      p0 = pulses;
      req_valid = 1'b1;
      req_a     = vecs[4].a;
      req_b     = vecs[4].b;
      req_tag   = vecs[4].tag;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
         chk("bp_rsp_r",     rsp_r,          64'd63);
         chk("bp_rsp_tag",   64'(rsp_tag),   64'd0);
         chk("bp_rsp_err",   64'(rsp_err),   64'd0);
         chk("bp_fifth_held", 64'(req_ready), 64'd0);
      end
      chk("bp_no_issue", 64'(pulses - p0), 64'd0);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      push(vecs[4].a, vecs[4].b, vecs[4].tag);
      for (int i = 0; i < 5; i++) begin
         get_rsp(r, tag, err, n);
         chk($sformatf("fill_r[%0d]", i),   r,        vecs[i].r);
         chk($sformatf("fill_tag[%0d]", i), 64'(tag), 64'(vecs[i].tag));
         chk($sformatf("fill_err[%0d]", i), 64'(err), 64'd0);
      end

      // Timeout, then a normal op
      stub_never = 1'b1;
      push(32'd4, 32'd4, 2'd2);
      get_rsp(r, tag, err, n);
      stub_never = 1'b0;
      chk("to_latency", 64'(n),   64'd65);
      chk("to_r",       r,        64'd0);
      chk("to_err",     64'(err), 64'd1);
      chk("to_tag",     64'(tag), 64'd2);
      push(32'd6, 32'd7, 2'd3);
      get_rsp(r, tag, err, n);
      chk("after_to_latency", 64'(n), 64'd35);
      chk("after_to_r",   r,        64'd42);
      chk("after_to_err", 64'(err), 64'd0);
      chk("after_to_tag", 64'(tag), 64'd3);

      // Stale done held high between ops
      stub_hold = 1'b1;
      push(32'hFFFF_FFFF, 32'd2, 2'd1);
      push(32'd3, 32'd3, 2'd2);
      get_rsp(r, tag, err, n);
      chk("stale_r0",   r,        64'h0000_0001_FFFF_FFFE);
      chk("stale_tag0", 64'(tag), 64'd1);
      get_rsp(r, tag, err, n);
      chk("stale_r1",   r,        64'd9);
      chk("stale_tag1", 64'(tag), 64'd2);
      stub_hold = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Reset while waiting with two ops queued
      push(32'd11, 32'd11, 2'd1);
      push(32'd12, 32'd12, 2'd2);
      push(32'd13, 32'd13, 2'd3);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      @(posedge clk); #3;
      rst_n = 1'b1;
      p0   = pulses;
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (rsp_valid) seen++;
      end
      chk("midrst_no_rsp",   64'(seen),          64'd0);
      chk("midrst_no_issue", 64'(pulses - p0),   64'd0);
      chk("midrst_busy",     64'(busy),          64'd0);
      chk("midrst_ready",    64'(req_ready),     64'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
